// File: rtl/fetch_controller.sv
// Fetch sequencer: steers the program counter, issues instruction-memory requests
// and hands fetched words to decode; redirects win over sequential advance.
module fetch_controller #(
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] pc_cur,
    output logic [15:0] pc_next,
    output logic        pc_en,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        instr_valid,
    output logic [15:0] instr_data,
    output logic [15:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_target,
    input  logic        resume,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DELIVER,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        squash_q, squash_d;
    logic        valid_q, valid_d;
    logic [15:0] data_q, data_d;
    logic [15:0] ipc_q, ipc_d;
    logic        halted_q, halted_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= 16'h0000;
            squash_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= 16'h0000;
            ipc_q    <= 16'h0000;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            squash_q <= squash_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            ipc_q    <= ipc_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        squash_d  = squash_q;
        valid_d   = valid_q;
        data_d    = data_q;
        ipc_d     = ipc_q;
        halted_d  = halted_q;
        pc_en     = 1'b0;
        pc_next   = 16'h0000;
        imem_req  = 1'b0;
        imem_addr = 16'h0000;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = pc_cur;
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redirect_target;
                    if (imem_ack) begin
                        state_d = S_REQ;
                    end else begin
                        // Memory still owes a response for the old address; drop it on arrival.
                        addr_d   = pc_cur;
                        squash_d = 1'b1;
                        state_d  = S_WAIT;
                    end
                end else if (imem_ack) begin
                    data_d  = imem_rdata;
                    ipc_d   = pc_cur;
                    valid_d = 1'b1;
                    state_d = S_DELIVER;
                end else begin
                    addr_d  = pc_cur;
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                imem_req  = 1'b1;
                imem_addr = addr_q;
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redirect_target;
                    if (imem_ack) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        squash_d = 1'b1;
                    end
                end else if (imem_ack) begin
                    if (squash_q) begin
                        squash_d = 1'b0;
                        state_d  = S_REQ;
                    end else begin
                        data_d  = imem_rdata;
                        ipc_d   = addr_q;
                        valid_d = 1'b1;
                        state_d = S_DELIVER;
                    end
                end
            end

            S_DELIVER: begin
                if (redirect_valid) begin
                    pc_en   = 1'b1;
                    pc_next = redirect_target;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    if (data_q[15:12] == HALT_OPCODE) begin
                        // PC is left pointing at the halt word; resume steps past it.
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else begin
                        pc_en   = 1'b1;
                        pc_next = pc_cur + 16'd1;
                        state_d = S_REQ;
                    end
                end
            end

            S_HALT: begin
                if (resume) begin
                    pc_en    = 1'b1;
                    pc_next  = pc_cur + 16'd1;
                    halted_d = 1'b0;
                    state_d  = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign instr_valid = valid_q;
    assign instr_data  = data_q;
    assign instr_pc    = ipc_q;
    assign halted      = halted_q;

endmodule
